// File: rtl/calc_display_fmt_if.sv
// Handshake bundle between the calculator core / display driver and the
// display formatter: a start request with its operand, and a digit stream.
interface calc_display_fmt_if;
    logic        start;
    logic [31:0] value;
    logic        err_in;
    logic        digit_ready;
    logic        digit_valid;
    logic [3:0]  digit;
    logic [2:0]  pos;
    logic        busy;
    logic        done;
    logic        err_flag;

    // Requesting side: issues format requests and consumes digits.
    modport master (
        output start, value, err_in, digit_ready,
        input  digit_valid, digit, pos, busy, done, err_flag
    );

    // Formatter side.
    modport slave (
        input  start, value, err_in, digit_ready,
        output digit_valid, digit, pos, busy, done, err_flag
    );
endinterface

// File: rtl/calc_display_fmt.sv
// Formats a 32-bit unsigned calculator result into eight display digits.
// Binary is converted to BCD with a one-bit-per-cycle double-dabble, then the
// digits are streamed MSD first over a valid/ready handshake with leading
// zeros blanked. Out-of-range or flagged results emit a blank/error pattern.
module calc_display_fmt #(
    parameter logic [3:0] BLANK_CODE = 4'hF,
    parameter logic [3:0] ERR_CODE   = 4'hE
) (
    input  logic              clock,
    input  logic              reset,
    calc_display_fmt_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CONVERT, EMIT, DONE} state_t;

    state_t      state_q;
    logic [31:0] bin_q;
    logic [39:0] bcd_q;
    logic [5:0]  cnt_q;
    logic        digit_valid_q;
    logic [3:0]  digit_q;
    logic [2:0]  pos_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic [39:0] bcd_adj;
    logic [39:0] bcd_d;
    logic        start_err;

    // Display code for position p: blank while every digit from p upward is
    // zero, except position 0 which always shows its digit.
    function automatic logic [3:0] fmt_digit(input logic [31:0] b, input logic [2:0] p);
        logic lead;
        lead = ((b >> {p, 2'b00}) == 32'd0) && (p != 3'd0);
        return lead ? BLANK_CODE : b[{p, 2'b00} +: 4];
    endfunction

    // Add-3 correction on each BCD digit ahead of the shift.
    for (genvar gi = 0; gi < 10; gi++) begin : g_add3
        assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                    bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
    end

    // Next BCD value: corrected digits shifted left, binary MSB shifted in.
    assign bcd_d = {bcd_adj[38:0], bin_q[31]};

    // Results that cannot be shown in eight digits, or flagged by the core.
    assign start_err = bus.err_in || (bus.value == 32'hFFFF_FFFF) ||
                       (bus.value > 32'd99_999_999);

    // Control FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            bin_q         <= '0;
            bcd_q         <= '0;
            cnt_q         <= '0;
            digit_valid_q <= 1'b0;
            digit_q       <= '0;
            pos_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        cnt_q  <= '0;
                        bcd_q  <= '0;
                        bin_q  <= bus.value;
                        if (start_err) begin
                            // Error pattern skips conversion; valid rises a cycle later.
                            state_q       <= EMIT;
                            err_q         <= 1'b1;
                            pos_q         <= 3'd7;
                            digit_q       <= BLANK_CODE;
                            digit_valid_q <= 1'b0;
                        end else begin
                            state_q <= CONVERT;
                        end
                    end
                end
                CONVERT: begin
                    bcd_q <= bcd_d;
                    bin_q <= {bin_q[30:0], 1'b0};
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        // Last shift: present the MSD straight from the final BCD.
                        state_q       <= EMIT;
                        digit_valid_q <= 1'b1;
                        pos_q         <= 3'd7;
                        digit_q       <= fmt_digit(bcd_d[31:0], 3'd7);
                    end
                end
                EMIT: begin
                    if (!digit_valid_q) begin
                        digit_valid_q <= 1'b1;
                    end else if (bus.digit_ready) begin
                        if (pos_q == 3'd0) begin
                            state_q       <= DONE;
                            digit_valid_q <= 1'b0;
                            done_q        <= 1'b1;
                        end else begin
                            pos_q <= pos_q - 3'd1;
                            if (err_q)
                                digit_q <= (pos_q == 3'd1) ? ERR_CODE : BLANK_CODE;
                            else
                                digit_q <= fmt_digit(bcd_q[31:0], pos_q - 3'd1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.digit_valid = digit_valid_q;
    assign bus.digit       = digit_q;
    assign bus.pos         = pos_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err_flag    = err_q;
endmodule

// File: tb/tb_calc_display_fmt.sv
// Directed bench for the display formatter: each task drives one scenario
// and checks outputs on the falling clock edge against hand-derived values.
module tb_calc_display_fmt;
    logic clk;
    logic reset;
    int   checks;
    int   passed;

    calc_display_fmt_if ifc ();

    calc_display_fmt #(
        .BLANK_CODE(4'hF),
        .ERR_CODE  (4'hE)
    ) dut (
        .clock(clk),
        .reset(reset),
        .bus  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_idle_outputs(input string name);
        checks++;
        if (ifc.digit_valid !== 1'b0 || ifc.digit !== 4'h0 || ifc.pos !== 3'd0 ||
            ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.err_flag !== 1'b0)
            $display("FAIL %s: valid=%b digit=%h pos=%0d busy=%b done=%b err=%b, required all 0",
                     name, ifc.digit_valid, ifc.digit, ifc.pos, ifc.busy, ifc.done, ifc.err_flag);
        else
            passed++;
    endtask

    // One complete format: start, latency, eight digits, done pulse, return to idle.
    task automatic run_format(input string name, input logic [31:0] v, input logic e,
                              input int exp_lat, input logic [31:0] exp_d, input logic exp_err,
                              input int stall_pos, input int stall_n);
        int j;
        @(negedge clk);
        ifc.start = 1'b1; ifc.value = v; ifc.err_in = e; ifc.digit_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Changing operands after capture must not disturb the result.
        ifc.start = 1'b0; ifc.value = 32'hDEAD_BEEF; ifc.err_in = 1'b1;
        j = 0;
        while (ifc.digit_valid !== 1'b1 && j < 100) begin
            @(negedge clk);
            j++;
        end
        checks++;
        if (j !== exp_lat) $display("FAIL %s latency: got %0d cycles, required %0d", name, j, exp_lat);
        else passed++;
        checks++;
        if (ifc.busy !== 1'b1) $display("FAIL %s busy: got %b, required 1", name, ifc.busy);
        else passed++;
        for (int p = 7; p >= 0; p--) begin
            if (p == stall_pos) begin
                ifc.digit_ready = 1'b0;
                repeat (stall_n) begin
                    @(negedge clk);
                    checks++;
                    if (ifc.digit_valid !== 1'b1 || ifc.pos !== 3'(p) || ifc.digit !== exp_d[p*4 +: 4])
                        $display("FAIL %s hold: valid=%b pos=%0d digit=%h, required 1/%0d/%h",
                                 name, ifc.digit_valid, ifc.pos, ifc.digit, p, exp_d[p*4 +: 4]);
                    else passed++;
                end
                ifc.digit_ready = 1'b1;
            end
            checks++;
            if (ifc.digit_valid !== 1'b1 || ifc.pos !== 3'(p) || ifc.digit !== exp_d[p*4 +: 4] ||
                ifc.err_flag !== exp_err)
                $display("FAIL %s digit: valid=%b pos=%0d digit=%h err=%b, required 1/%0d/%h/%b",
                         name, ifc.digit_valid, ifc.pos, ifc.digit, ifc.err_flag, p, exp_d[p*4 +: 4], exp_err);
            else passed++;
            @(negedge clk);
        end
        checks++;
        if (ifc.done !== 1'b1 || ifc.digit_valid !== 1'b0 || ifc.busy !== 1'b1 || ifc.err_flag !== exp_err)
            $display("FAIL %s done: done=%b valid=%b busy=%b err=%b, required 1/0/1/%b",
                     name, ifc.done, ifc.digit_valid, ifc.busy, ifc.err_flag, exp_err);
        else passed++;
        // A start coinciding with done is ignored.
        ifc.start = 1'b1; ifc.value = 32'd5; ifc.err_in = 1'b0;
        @(negedge clk);
        ifc.start = 1'b0;
        checks++;
        if (ifc.done !== 1'b0 || ifc.busy !== 1'b0 || ifc.digit_valid !== 1'b0 || ifc.err_flag !== 1'b0)
            $display("FAIL %s idle: done=%b busy=%b valid=%b err=%b, required 0/0/0/0",
                     name, ifc.done, ifc.busy, ifc.digit_valid, ifc.err_flag);
        else passed++;
        @(negedge clk);
        checks++;
        if (ifc.busy !== 1'b0) $display("FAIL %s start_in_done: busy=%b, required 0", name, ifc.busy);
        else passed++;
        $display("format %s value=%0d err_in=%b done", name, v, e);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");
    endtask

    task automatic test_normal;
        run_format("v1234", 32'd1234, 1'b0, 32, 32'hFFFF_1234, 1'b0, -1, 0);
        run_format("v0", 32'd0, 1'b0, 32, 32'hFFFF_FFF0, 1'b0, -1, 0);
        run_format("vmax", 32'd99_999_999, 1'b0, 32, 32'h9999_9999, 1'b0, -1, 0);
        run_format("v10M", 32'd10_000_000, 1'b0, 32, 32'h1000_0000, 1'b0, -1, 0);
    endtask

    task automatic test_errors;
        run_format("v100M", 32'd100_000_000, 1'b0, 1, 32'hFFFF_FFFE, 1'b1, -1, 0);
        run_format("vall1", 32'hFFFF_FFFF, 1'b0, 1, 32'hFFFF_FFFE, 1'b1, -1, 0);
        run_format("errin", 32'd42, 1'b1, 1, 32'hFFFF_FFFE, 1'b1, -1, 0);
    endtask

    task automatic test_stall;
        run_format("stall", 32'd50_607_080, 1'b0, 32, 32'h5060_7080, 1'b0, 5, 3);
    endtask

    task automatic test_reset_mid_convert;
        int j;
        bit seen;
        @(negedge clk);
        ifc.start = 1'b1; ifc.value = 32'd1234; ifc.err_in = 1'b0; ifc.digit_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
        for (j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (j == 5) begin ifc.start = 1'b1; ifc.value = 32'd0; ifc.err_in = 1'b1; end
            if (j == 6) ifc.start = 1'b0;
        end
        checks++;
        if (ifc.busy !== 1'b1 || ifc.digit_valid !== 1'b0 || ifc.err_flag !== 1'b0)
            $display("FAIL busy_start: busy=%b valid=%b err=%b, required 1/0/0",
                     ifc.busy, ifc.digit_valid, ifc.err_flag);
        else passed++;
        // Reset wins over a simultaneous start.
        reset = 1'b1; ifc.start = 1'b1; ifc.value = 32'd9;
        @(negedge clk);
        check_idle_outputs("reset_mid_convert");
        reset = 1'b0; ifc.start = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ifc.digit_valid !== 1'b0 || ifc.busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) $display("FAIL no_resume: activity after reset, required none");
        else passed++;
        $display("reset mid-convert done");
        run_format("v7", 32'd7, 1'b0, 32, 32'hFFFF_FFF7, 1'b0, -1, 0);
    endtask

    task automatic test_reset_mid_emit;
        int j;
        @(negedge clk);
        ifc.start = 1'b1; ifc.value = 32'd123; ifc.err_in = 1'b0; ifc.digit_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
        j = 0;
        while (ifc.digit_valid !== 1'b1 && j < 100) begin
            @(negedge clk);
            j++;
        end
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_mid_emit");
        reset = 1'b0;
        ifc.digit_ready = 1'b1;
        $display("reset mid-emit done");
    endtask

    initial begin
        checks = 0;
        passed = 0;
        reset = 1'b1;
        ifc.start = 1'b0;
        ifc.value = '0;
        ifc.err_in = 1'b0;
        ifc.digit_ready = 1'b1;
        test_reset;
        test_normal;
        test_errors;
        test_stall;
        test_reset_mid_convert;
        test_reset_mid_emit;
        run_format("back", 32'd1234, 1'b0, 32, 32'hFFFF_1234, 1'b0, -1, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
